seg7_scan4: RTL and testbench



---
 rtl/seg7_scan4.sv | 134 +++++++++++++
 tb/tb_seg7_scan4.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan4.sv
// Four-digit multiplexed 7-segment driver with snapshot capture.
// Leading-zero blanking is built when SEG7_LZ_BLANK_EN is defined.
module seg7_scan4 #(
    parameter int PRESCALE       = 4,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        cap,
    input  logic [15:0] din,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame
);

    localparam logic        POL_LO   = (SEG_ACTIVE_LOW != 0);
    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);
    localparam logic [3:0]  AN_OFF   = POL_LO ? 4'b1111 : 4'b0000;
    localparam logic [6:0]  SEG_OFF  = POL_LO ? 7'h7F : 7'h00;

    logic [15:0] r_pre;
    logic [1:0]  r_idx;
    logic [15:0] r_snap;
    logic [3:0]  r_an;
    logic [6:0]  r_seg;
    logic        r_frame;

    logic        w_pre_end;
    logic        w_adv;
    logic [3:0]  w_nib;
    logic [6:0]  w_font;
    logic        w_blank;
    logic [3:0]  w_an_hi;
    logic [6:0]  w_seg_hi;
    logic [3:0]  w_an_pin;
    logic [6:0]  w_seg_pin;

    assign w_pre_end = (r_pre == PRE_LAST);
    assign w_adv     = ena && w_pre_end;

    always_comb begin
        w_nib = r_snap[3:0];
        unique case (r_idx)
            2'd0: w_nib = r_snap[3:0];
            2'd1: w_nib = r_snap[7:4];
            2'd2: w_nib = r_snap[11:8];
            2'd3: w_nib = r_snap[15:12];
        endcase
    end

    // Active-high gfedcba glyphs for hex digits
    always_comb begin
        w_font = 7'h00;
        unique case (w_nib)
            4'h0: w_font = 7'h3F;
            4'h1: w_font = 7'h06;
            4'h2: w_font = 7'h5B;
            4'h3: w_font = 7'h4F;
            4'h4: w_font = 7'h66;
            4'h5: w_font = 7'h6D;
            4'h6: w_font = 7'h7D;
            4'h7: w_font = 7'h07;
            4'h8: w_font = 7'h7F;
            4'h9: w_font = 7'h6F;
            4'hA: w_font = 7'h77;
            4'hB: w_font = 7'h7C;
            4'hC: w_font = 7'h39;
            4'hD: w_font = 7'h5E;
            4'hE: w_font = 7'h79;
            4'hF: w_font = 7'h71;
        endcase
    end

`ifdef SEG7_LZ_BLANK_EN
    // A digit is blank when it and every digit to its left are zero
    always_comb begin
        w_blank = 1'b0;
        unique case (1'b1)
            (r_idx == 2'd3): w_blank = (r_snap[15:12] == 4'h0);
            (r_idx == 2'd2): w_blank = (r_snap[15:8] == 8'h00);
            (r_idx == 2'd1): w_blank = (r_snap[15:4] == 12'h000);
            default:         w_blank = 1'b0;
        endcase
    end
`else
    assign w_blank = 1'b0;
`endif

    assign w_an_hi   = 4'b0001 << r_idx;
    assign w_seg_hi  = w_blank ? 7'h00 : w_font;
    assign w_an_pin  = POL_LO ? ~w_an_hi : w_an_hi;
    assign w_seg_pin = POL_LO ? ~w_seg_hi : w_seg_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= 16'd0;
            r_idx <= 2'd0;
        end else if (ena) begin
            if (w_pre_end) begin
                r_pre <= 16'd0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_pre <= r_pre + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap <= 16'h0000;
        end else if (cap) begin
            r_snap <= din;
        end
    end

    // Outputs sample pre-edge idx/snap, so they trail both by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an    <= AN_OFF;
            r_seg   <= SEG_OFF;
            r_frame <= 1'b0;
        end else begin
            r_an    <= w_an_pin;
            r_seg   <= w_seg_pin;
            r_frame <= w_adv && (r_idx == 2'd3);
        end
    end

    assign an    = r_an;
    assign seg   = r_seg;
    assign frame = r_frame;

endmodule

// File: tb/tb_seg7_scan4.sv
// Bench for seg7_scan4: arithmetic display model plus directed cases.
// Blanking expectations follow SEG7_LZ_BLANK_EN when it is defined.
module tb_seg7_scan4;

    localparam int P = 2;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        cap;
    logic [15:0] din;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_on = 0;

    seg7_scan4 #(
        .PRESCALE      (P),
        .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ena  (ena),
        .cap  (cap),
        .din  (din),
        .an   (an),
        .seg  (seg),
        .frame(frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] font [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Model: enabled-cycle count within a frame sets the digit
    int          m_cnt;
    logic [15:0] m_snap;
    logic [3:0]  m_an;
    logic [6:0]  m_seg;
    logic        m_frame;

    function automatic logic [6:0] glyph(logic [15:0] s, int d);
        logic [15:0] rest;
        logic [3:0]  nib;
        rest = s >> (4 * d);
        nib  = rest[3:0];
`ifdef SEG7_LZ_BLANK_EN
        if (d > 0 && rest == 16'h0) return 7'h7F;
`endif
        return ~font[nib];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt   <= 0;
            m_snap  <= 16'h0;
            m_an    <= 4'b1111;
            m_seg   <= 7'h7F;
            m_frame <= 1'b0;
        end else begin
            m_an    <= ~(4'b0001 << (m_cnt / P));
            m_seg   <= glyph(m_snap, m_cnt / P);
            m_frame <= ena && (m_cnt == 4 * P - 1);
            if (ena) m_cnt <= (m_cnt + 1) % (4 * P);
            if (cap) m_snap <= din;
        end
    end

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_an", 16'(an), 16'(m_an));
            chk("model_seg", 16'(seg), 16'(m_seg));
            chk("model_frame", 16'(frame), 16'(m_frame));
        end
    end

    task automatic wait_cnt(int v);
        bit hit;
        hit = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (m_cnt == v) begin
                hit = 1;
                break;
            end
        end
        n_chk++;
        if (!hit) begin
            n_fail++;
            $display("FAIL wait_cnt: got timeout expected cnt %0d", v);
        end
    endtask

    task automatic lit(string nm, logic [3:0] ea, logic [6:0] es,
                       logic ef);
        chk({nm, "_an"}, 16'(an), 16'(ea));
        chk({nm, "_seg"}, 16'(seg), 16'(es));
        chk({nm, "_frame"}, 16'(frame), 16'(ef));
    endtask

    logic [3:0] exp_an [8] = '{
        4'b1110, 4'b1110, 4'b1101, 4'b1101,
        4'b1011, 4'b1011, 4'b0111, 4'b0111
    };
    logic [6:0] exp_seg [8] = '{
        7'b0010010, 7'b0010010, 7'b1111000, 7'b1111000,
        7'b0001000, 7'b0001000, 7'b0110000, 7'b0110000
    };

    initial begin
        rst_n = 1'b0;
        ena   = 1'b0;
        cap   = 1'b0;
        din   = 16'h0;
        #12;
        lit("reset", 4'b1111, 7'b1111111, 1'b0);
        chk_on = 1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        lit("first_edge", 4'b1110, 7'b1000000, 1'b0);

        @(negedge clk);
        din = 16'h3A75;
        cap = 1'b1;
        @(negedge clk);
        cap = 1'b0;
        ena = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            lit($sformatf("scan%0d", k), exp_an[k], exp_seg[k],
                k == 7);
        end

        wait_cnt(5);
        ena = 1'b0;
        @(negedge clk);
        @(negedge clk);
        din = 16'h0F00;
        cap = 1'b1;
        @(negedge clk);
        cap = 1'b0;
        @(posedge clk); #1;
        lit("hold_cap", 4'b1011, 7'b0001110, 1'b0);
        @(negedge clk);
        ena = 1'b1;

        wait_cnt(1);
        din = 16'h0090;
        cap = 1'b1;
        @(posedge clk); #1;
        lit("cap_adv_old", 4'b1110, 7'b1000000, 1'b0);
        @(negedge clk);
        cap = 1'b0;
        @(posedge clk); #1;
        lit("cap_adv_new", 4'b1101, 7'b0010000, 1'b0);

        wait_cnt(6);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        lit("async_rst", 4'b1111, 7'b1111111, 1'b0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        lit("post_rst", 4'b1110, 7'b1000000, 1'b0);

        @(negedge clk);
        din = 16'h0040;
        cap = 1'b1;
        @(negedge clk);
        cap = 1'b0;
        wait_cnt(6);
        @(posedge clk); #1;
`ifdef SEG7_LZ_BLANK_EN
        lit("lz_d3", 4'b0111, 7'b1111111, 1'b0);
`else
        lit("lz_d3", 4'b0111, 7'b1000000, 1'b0);
`endif
        wait_cnt(2);
        @(posedge clk); #1;
        lit("lz_d1", 4'b1101, 7'b0011001, 1'b0);
        wait_cnt(0);
        @(posedge clk); #1;
        lit("lz_d0", 4'b1110, 7'b1000000, 1'b0);

        repeat (10) @(posedge clk);
        @(negedge clk);
        chk_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
